// File: rtl/bb_share_arbiter_if.sv
// Bundle of requester-side and black-box-side signals around the shared compute unit.
// The slave modport is the arbiter's view; master is the view of the surrounding top level.
interface bb_share_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op_a;
    logic [NREQ-1:0] op_b;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            bb_in1;
    logic            bb_in2;
    logic            bb_en;
    logic            bb_out1;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_data;

    modport slave (
        input  req, op_a, op_b, bb_out1,
        output gnt, busy, bb_in1, bb_in2, bb_en, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req, op_a, op_b, bb_out1,
        input  gnt, busy, bb_in1, bb_in2, bb_en, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/bb_share_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency 1-bit black box among NREQ requesters.
// Each operation runs IDLE -> ISSUE -> WAIT -> DONE; every output comes straight from a register.
module bb_share_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bb_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr, rr_ptr_n;
    logic [3:0]      cnt, cnt_n;
    logic [NREQ-1:0] gnt, gnt_n;
    logic            busy, busy_n;
    logic            bb_in1, bb_in1_n;
    logic            bb_in2, bb_in2_n;
    logic            bb_en, bb_en_n;
    logic            rsp_valid, rsp_valid_n;
    logic [IDW-1:0]  rsp_id, rsp_id_n;
    logic            rsp_data, rsp_data_n;
    logic [IDW-1:0]  sel;
    logic            found;

    // First requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        int idx;
        logic [IDW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        cnt_n       = cnt;
        gnt_n       = '0;
        busy_n      = busy;
        bb_in1_n    = bb_in1;
        bb_in2_n    = bb_in2;
        bb_en_n     = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_id_n    = rsp_id;
        rsp_data_n  = rsp_data;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n[sel] = 1'b1;
                    bb_in1_n   = bus.op_a[sel];
                    bb_in2_n   = bus.op_b[sel];
                    bb_en_n    = 1'b1;
                    busy_n     = 1'b1;
                    rsp_id_n   = sel;
                    rr_ptr_n   = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = 4'(LAT - 1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    rsp_data_n  = bus.bb_out1;
                    rsp_valid_n = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            bb_in1    <= 1'b0;
            bb_in2    <= 1'b0;
            bb_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            busy      <= busy_n;
            bb_in1    <= bb_in1_n;
            bb_in2    <= bb_in2_n;
            bb_en     <= bb_en_n;
            rsp_valid <= rsp_valid_n;
            rsp_id    <= rsp_id_n;
            rsp_data  <= rsp_data_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.busy      = busy;
    assign bus.bb_in1    = bb_in1;
    assign bus.bb_in2    = bb_in2;
    assign bus.bb_en     = bb_en;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
endmodule

// File: doc/bb_share_arbiter.md
Name: bb_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one black-box compute unit (two 1-bit operands, one 1-bit result) between NREQ requesters. It grants one requester at a time, latches that requester's operands and drives them to the unit. It pulses the unit enable, waits a fixed latency, captures the result and returns it with the requester ID. It sits between requester logic in the top level and the single black-box instance.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
LAT, 2, cycles from the end of the bb_en pulse to result capture; legal range 1..15.
IDW, $clog2(NREQ), width of rsp_id; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on posedge clk.
rst_n  input  1  synchronous reset, active-low.
req  input  NREQ  request per requester; held high until granted.
op_a  input  NREQ  operand in1, one bit per requester.
op_b  input  NREQ  operand in2, one bit per requester.
gnt  output  NREQ  one-hot grant, one-cycle pulse.
busy  output  1  high whenever the FSM is not in IDLE.
bb_in1  output  1  latched operand a to the black box.
bb_in2  output  1  latched operand b to the black box.
bb_en  output  1  one-cycle operation strobe to the black box.
bb_out1  input  1  black-box result.
rsp_valid  output  1  one-cycle result strobe.
rsp_id  output  IDW  index of the requester that owns rsp_data.
rsp_data  output  1  captured bb_out1.

Behaviour:
- All outputs are registered.
- Reset: while rst_n==0 at posedge:
  - state=IDLE, rr_ptr=0, cnt=0;
  - gnt, busy, bb_in1, bb_in2, bb_en, rsp_valid, rsp_id and rsp_data all 0.
- Reset mid-operation aborts the operation. No rsp_valid is ever issued for an aborted operation.
- IDLE:
  - If req!=0, select the first set bit scanning upward from rr_ptr with wrap-around mod NREQ. Call it index i.
  - Next state: gnt=onehot(i), bb_in1=op_a[i], bb_in2=op_b[i], bb_en=1, busy=1, rsp_id=i, rr_ptr=(i+1) mod NREQ, state=ISSUE.
  - If req==0, stay in IDLE with all strobes at 0.
- ISSUE: gnt=0, bb_en=0, cnt=LAT-1, state=WAIT.
- WAIT:
  - cnt!=0: decrement cnt.
  - cnt==0: rsp_data=bb_out1, rsp_valid=1, state=DONE.
- DONE: rsp_valid=0, busy=0, state=IDLE.
  - A new request is sampled at the edge after DONE.
  - No back-to-back overlap between operations.
- Latency: req sampled at edge E0 gives gnt/bb_en high after E0 and rsp_valid high after E(LAT+1).
  - Throughput: one operation per LAT+3 cycles.
- bb_in1 and bb_in2 hold their latched values from ISSUE through DONE. They change only at the next grant.
- req and op values are ignored outside IDLE.
  - A requester that drops req before being granted loses the request silently.
  - A requester keeps its place in the rotation; rr_ptr is unaffected by the drop.
- Simultaneous requests: exactly one gnt bit per grant cycle. Fairness: every continuously asserted requester is granted within NREQ operations.
- rr_ptr wraps from NREQ-1 to 0.
- gnt is never asserted in the same cycle as rsp_valid.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 → every output is 0 and no gnt is issued. After release, the first gnt is 4'b0001.
- Single op: req=4'b0100, op_a[2]=1, op_b[2]=0, bb_out1 model returns in1^in2, LAT=2:
  - gnt=4'b0100 and bb_en=1 after E0, bb_in1=1, bb_in2=0;
  - rsp_valid=1 after E3, rsp_id=2, rsp_data=1;
  - busy low after E4.
- Round-robin: req=4'b1111 held → grant order 0,1,2,3,0. Consecutive grants are LAT+3=5 cycles apart.
- Skip and wrap: rr_ptr=3 with req=4'b0011 → grant goes to 0, then to 1.
- Dropped request: req[1] pulses for 1 cycle while busy → no gnt[1] and no response with rsp_id=1.
- Reset mid-op: assert rst_n=0 during WAIT → no rsp_valid, state=IDLE, and the next grant starts the scan from index 0.
